// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a small run-control FSM.
// Drives the instruction-ROM address, registers the returned word for the
// control decoder, squashes the fall-through fetch on a taken branch (one
// bubble), and handshakes program completion through Start/Ack.
// Optional build macro FETCH_BRANCH_LUT_EN: branch targets come from a
// 16-entry constant table indexed by TargetSel[3:0] instead of a
// PC-relative signed offset.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int MCODEBITS = 9
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Stall,
    input  logic                 Branch,
    input  logic                 Taken,
    input  logic                 Halt,
    input  logic [PC_W-1:0]      TargetSel,
    input  logic [MCODEBITS-1:0] InstrIn,
    output logic [PC_W-1:0]      ProgCtr,
    output logic [MCODEBITS-1:0] InstrOut,
    output logic                 Valid,
    output logic                 Ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [PC_W-1:0]        pc_r;
    logic [PC_W-1:0]        pc_nxt_s;
    logic [MCODEBITS-1:0]   instr_r;
    logic [MCODEBITS-1:0]   instr_nxt_s;
    logic                   valid_r;
    logic                   valid_nxt_s;
    logic                   ack_r;
    logic                   ack_nxt_s;
    logic [PC_W-1:0]        branch_target_s;

`ifdef FETCH_BRANCH_LUT_EN
    // Constant branch-target table; entry i is i*8, except entry 15 which is
    // the last address so a table branch can reach the top of program space.
    function automatic logic [PC_W-1:0] lut_target(input logic [3:0] idx);
        case (idx)
            4'd0:    lut_target = PC_W'(10'h000);
            4'd1:    lut_target = PC_W'(10'h008);
            4'd2:    lut_target = PC_W'(10'h010);
            4'd3:    lut_target = PC_W'(10'h018);
            4'd4:    lut_target = PC_W'(10'h020);
            4'd5:    lut_target = PC_W'(10'h028);
            4'd6:    lut_target = PC_W'(10'h030);
            4'd7:    lut_target = PC_W'(10'h038);
            4'd8:    lut_target = PC_W'(10'h040);
            4'd9:    lut_target = PC_W'(10'h048);
            4'd10:   lut_target = PC_W'(10'h050);
            4'd11:   lut_target = PC_W'(10'h058);
            4'd12:   lut_target = PC_W'(10'h060);
            4'd13:   lut_target = PC_W'(10'h068);
            4'd14:   lut_target = PC_W'(10'h070);
            4'd15:   lut_target = {PC_W{1'b1}};
            default: lut_target = {PC_W{1'b0}};
        endcase
    endfunction

    // Only the low four select bits index the table; the rest are don't-care.
    logic unused_tsel_s;
    assign unused_tsel_s = ^TargetSel[PC_W-1:4];

    // Table lookup of the branch target.
    always_comb begin
        branch_target_s = lut_target(TargetSel[3:0]);
    end
`else
    // PC-relative target: the branch sits at ProgCtr-1 (its word is on
    // InstrOut), TargetSel is a two's-complement offset, result wraps.
    always_comb begin
        branch_target_s = pc_r - PC_W'(1'b1) + TargetSel;
    end
`endif

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-datapath decode; priority Stall > Halt > taken
    // branch > increment, and control inputs only count while Valid is set.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        valid_nxt_s = valid_r;
        case (state_r)
            IDLE: begin
                pc_nxt_s    = {PC_W{1'b0}};
                valid_nxt_s = 1'b0;
                if (Start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (Stall) begin
                    state_nxt_s = RUN;
                end else if (valid_r && Halt) begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = DONE;
                end else if (valid_r && Branch && Taken) begin
                    pc_nxt_s    = branch_target_s;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = FLUSH;
                end else begin
                    instr_nxt_s = InstrIn;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_r + PC_W'(1'b1);
                end
            end
            FLUSH: begin
                // Fetch the branch target itself; this cycle is the bubble.
                if (Stall) begin
                    state_nxt_s = FLUSH;
                end else begin
                    instr_nxt_s = InstrIn;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_r + PC_W'(1'b1);
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                valid_nxt_s = 1'b0;
                if (!Start) begin
                    pc_nxt_s    = {PC_W{1'b0}};
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                pc_nxt_s    = {PC_W{1'b0}};
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
        ack_nxt_s = (state_nxt_s == DONE);
    end

    // Registered datapath and handshake outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_r    <= {PC_W{1'b0}};
            instr_r <= {MCODEBITS{1'b0}};
            valid_r <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            valid_r <= valid_nxt_s;
            ack_r   <= ack_nxt_s;
        end
    end

    assign ProgCtr  = pc_r;
    assign InstrOut = instr_r;
    assign Valid    = valid_r;
    assign Ack      = ack_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (PC_W=10, MCODEBITS=9). The ROM is a
// combinational model: ROM[a] = a[8:0] ^ 9'h155.
module tb_fetch_unit;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Stall;
    logic       Branch;
    logic       Taken;
    logic       Halt;
    logic [9:0] TargetSel;
    logic [8:0] InstrIn;
    logic [9:0] ProgCtr;
    logic [8:0] InstrOut;
    logic       Valid;
    logic       Ack;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FETCH_BRANCH_LUT_EN
    localparam logic [9:0] STALL_TGT = 10'h020;  // LUT[4]
    localparam logic [9:0] WRAP_SEL  = 10'h00F;  // LUT[15] = 0x3FF
`else
    localparam logic [9:0] STALL_TGT = 10'h007;  // branch at 3, offset +4
    localparam logic [9:0] WRAP_SEL  = 10'h3FE;  // branch at 1, offset +0x3FE
`endif

    fetch_unit #(.PC_W(10), .MCODEBITS(9)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .Branch(Branch), .Taken(Taken), .Halt(Halt), .TargetSel(TargetSel),
        .InstrIn(InstrIn), .ProgCtr(ProgCtr), .InstrOut(InstrOut),
        .Valid(Valid), .Ack(Ack)
    );

    function automatic logic [8:0] rom_f(input logic [9:0] a);
        rom_f = a[8:0] ^ 9'h155;
    endfunction

    assign InstrIn = rom_f(ProgCtr);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctl;
        Stall = 1'b0; Branch = 1'b0; Taken = 1'b0; Halt = 1'b0;
        TargetSel = 10'd0;
    endtask

    // Reset, then Start: leaves the DUT in RUN with ProgCtr=0, Valid=0.
    task automatic start_run;
        clear_ctl();
        Start = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Start = 1'b1;
        tick();
    endtask

    // After this, the word at addr is on InstrOut, Valid=1, ProgCtr=addr+1.
    task automatic go_to(input int addr);
        start_run();
        repeat (addr + 1) tick();
    endtask

    task automatic test_reset;
        clear_ctl();
        Start = 1'b0;
        Reset = 1'b0;
        tick();
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (ProgCtr !== 10'd0) begin n_err++; $display("FAIL reset_pc: got %h want %h", ProgCtr, 10'd0); end
        n_cmp++; if (InstrOut !== 9'd0) begin n_err++; $display("FAIL reset_instr: got %h want %h", InstrOut, 9'd0); end
        n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", Valid); end
        n_cmp++; if (Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", Ack); end
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if (ProgCtr !== 10'd0 || Valid !== 1'b0) begin n_err++; $display("FAIL idle_hold: got pc=%h v=%b want pc=000 v=0", ProgCtr, Valid); end
    endtask

    task automatic test_sequential;
        start_run();
        n_cmp++; if (ProgCtr !== 10'd0 || Valid !== 1'b0) begin n_err++; $display("FAIL seq_first: got pc=%h v=%b want pc=000 v=0", ProgCtr, Valid); end
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++; if (ProgCtr !== 10'(n + 1)) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", n, ProgCtr, 10'(n + 1)); end
            n_cmp++; if (InstrOut !== rom_f(10'(n)) || Valid !== 1'b1) begin n_err++; $display("FAIL seq_instr%0d: got %h v=%b want %h v=1", n, InstrOut, Valid, rom_f(10'(n))); end
        end
    endtask

    task automatic test_ignore_invalid;
        start_run();
        Halt = 1'b1; Branch = 1'b1; Taken = 1'b1; TargetSel = 10'd4;
        tick();
        clear_ctl();
        n_cmp++; if (ProgCtr !== 10'd1 || Valid !== 1'b1 || Ack !== 1'b0) begin n_err++; $display("FAIL ignore_invalid: got pc=%h v=%b ack=%b want pc=001 v=1 ack=0", ProgCtr, Valid, Ack); end
    endtask

`ifdef FETCH_BRANCH_LUT_EN
    task automatic test_branch_lut;
        go_to(5);
        Branch = 1'b1; Taken = 1'b1; TargetSel = 10'h3F4;  // index 4, upper bits set
        tick();
        clear_ctl();
        n_cmp++; if (ProgCtr !== 10'h020 || Valid !== 1'b0) begin n_err++; $display("FAIL lut_target: got pc=%h v=%b want pc=020 v=0", ProgCtr, Valid); end
        tick();
        n_cmp++; if (InstrOut !== rom_f(10'h020) || Valid !== 1'b1 || ProgCtr !== 10'h021) begin n_err++; $display("FAIL lut_flush: got i=%h v=%b pc=%h want i=%h v=1 pc=021", InstrOut, Valid, ProgCtr, rom_f(10'h020)); end
    endtask
`else
    task automatic test_branch_offset;
        go_to(5);
        Branch = 1'b1; Taken = 1'b1; TargetSel = 10'h3FD;  // -3
        tick();
        clear_ctl();
        n_cmp++; if (ProgCtr !== 10'd2 || Valid !== 1'b0) begin n_err++; $display("FAIL ofs_target: got pc=%h v=%b want pc=002 v=0", ProgCtr, Valid); end
        tick();
        n_cmp++; if (InstrOut !== rom_f(10'd2) || Valid !== 1'b1 || ProgCtr !== 10'd3) begin n_err++; $display("FAIL ofs_flush: got i=%h v=%b pc=%h want i=%h v=1 pc=003", InstrOut, Valid, ProgCtr, rom_f(10'd2)); end
        tick();
        n_cmp++; if (InstrOut !== rom_f(10'd3) || ProgCtr !== 10'd4) begin n_err++; $display("FAIL ofs_after: got i=%h pc=%h want i=%h pc=004", InstrOut, ProgCtr, rom_f(10'd3)); end
    endtask
`endif

    task automatic test_not_taken;
        go_to(5);
        Branch = 1'b1; Taken = 1'b0; TargetSel = 10'd4;
        tick();
        clear_ctl();
        n_cmp++; if (ProgCtr !== 10'd7 || Valid !== 1'b1 || InstrOut !== rom_f(10'd6)) begin n_err++; $display("FAIL not_taken: got pc=%h v=%b i=%h want pc=007 v=1 i=%h", ProgCtr, Valid, InstrOut, rom_f(10'd6)); end
    endtask

    task automatic test_stall;
        go_to(3);
        Stall = 1'b1; Branch = 1'b1; Taken = 1'b1; TargetSel = 10'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (ProgCtr !== 10'd4 || InstrOut !== rom_f(10'd3) || Valid !== 1'b1) begin n_err++; $display("FAIL stall_hold%0d: got pc=%h i=%h v=%b want pc=004 i=%h v=1", k, ProgCtr, InstrOut, Valid, rom_f(10'd3)); end
        end
        Stall = 1'b0;
        tick();
        clear_ctl();
        n_cmp++; if (ProgCtr !== STALL_TGT || Valid !== 1'b0) begin n_err++; $display("FAIL stall_branch: got pc=%h v=%b want pc=%h v=0", ProgCtr, Valid, STALL_TGT); end
        tick();
        n_cmp++; if (InstrOut !== rom_f(STALL_TGT) || ProgCtr !== STALL_TGT + 10'd1) begin n_err++; $display("FAIL stall_flush: got i=%h pc=%h want i=%h pc=%h", InstrOut, ProgCtr, rom_f(STALL_TGT), STALL_TGT + 10'd1); end
    endtask

    task automatic test_halt;
        go_to(7);
        Halt = 1'b1; Branch = 1'b1; Taken = 1'b1; TargetSel = 10'd4;
        tick();
        clear_ctl();
        n_cmp++; if (Ack !== 1'b1 || Valid !== 1'b0 || ProgCtr !== 10'd8) begin n_err++; $display("FAIL halt_done: got ack=%b v=%b pc=%h want ack=1 v=0 pc=008", Ack, Valid, ProgCtr); end
        repeat (2) tick();
        n_cmp++; if (Ack !== 1'b1 || Valid !== 1'b0) begin n_err++; $display("FAIL halt_hold: got ack=%b v=%b want ack=1 v=0", Ack, Valid); end
        Start = 1'b0;
        tick();
        n_cmp++; if (Ack !== 1'b0 || ProgCtr !== 10'd0 || Valid !== 1'b0) begin n_err++; $display("FAIL halt_idle: got ack=%b pc=%h v=%b want ack=0 pc=000 v=0", Ack, ProgCtr, Valid); end
    endtask

    task automatic test_reset_flush;
        go_to(5);
        Branch = 1'b1; Taken = 1'b1; TargetSel = 10'd4;
        tick();
        clear_ctl();
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (ProgCtr !== 10'd0 || InstrOut !== 9'd0 || Valid !== 1'b0 || Ack !== 1'b0) begin n_err++; $display("FAIL rst_flush: got pc=%h i=%h v=%b ack=%b want all zero", ProgCtr, InstrOut, Valid, Ack); end
        #1 Reset = 1'b0;
        Start = 1'b0;
        tick();
        Start = 1'b1;
        tick();
        n_cmp++; if (ProgCtr !== 10'd0 || Valid !== 1'b0) begin n_err++; $display("FAIL rst_idle: got pc=%h v=%b want pc=000 v=0", ProgCtr, Valid); end
        tick();
        n_cmp++; if (ProgCtr !== 10'd1 || InstrOut !== rom_f(10'd0) || Valid !== 1'b1) begin n_err++; $display("FAIL rst_restart: got pc=%h i=%h v=%b want pc=001 i=%h v=1", ProgCtr, InstrOut, Valid, rom_f(10'd0)); end
    endtask

    task automatic test_wrap;
        go_to(1);
        Branch = 1'b1; Taken = 1'b1; TargetSel = WRAP_SEL;
        tick();
        clear_ctl();
        n_cmp++; if (ProgCtr !== 10'h3FF || Valid !== 1'b0) begin n_err++; $display("FAIL wrap_target: got pc=%h v=%b want pc=3ff v=0", ProgCtr, Valid); end
        tick();
        n_cmp++; if (ProgCtr !== 10'd0 || InstrOut !== rom_f(10'h3FF) || Valid !== 1'b1) begin n_err++; $display("FAIL wrap_pc: got pc=%h i=%h v=%b want pc=000 i=%h v=1", ProgCtr, InstrOut, Valid, rom_f(10'h3FF)); end
        tick();
        n_cmp++; if (ProgCtr !== 10'd1 || InstrOut !== rom_f(10'd0)) begin n_err++; $display("FAIL wrap_next: got pc=%h i=%h want pc=001 i=%h", ProgCtr, InstrOut, rom_f(10'd0)); end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        clear_ctl();
        test_reset();
        test_sequential();
        test_ignore_invalid();
`ifdef FETCH_BRANCH_LUT_EN
        test_branch_lut();
`else
        test_branch_offset();
`endif
        test_not_taken();
        test_stall();
        test_halt();
        test_reset_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width.
REQ-002 SHALL have parameter MCODEBITS, default 9, instruction width fed to the control decoder.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  level; begin program execution from address 0.
REQ-006 SHALL have port Stall  input  1  freeze PC and instruction register.
REQ-007 SHALL have port Branch  input  1  branch decoded for the instruction currently on InstrOut.
REQ-008 SHALL have port Taken  input  1  branch condition true (ALU compare result).
REQ-009 SHALL have port Halt  input  1  halt decoded for the instruction currently on InstrOut.
REQ-010 SHALL have port TargetSel  input  PC_W  branch operand: LUT index or signed offset (see Configuration).
REQ-011 SHALL have port InstrIn  input  MCODEBITS  combinational instruction-ROM read data at ProgCtr.
REQ-012 SHALL have port ProgCtr  output  PC_W  instruction-ROM address.
REQ-013 SHALL have port InstrOut  output  MCODEBITS  registered instruction to the control decoder.
REQ-014 SHALL have port Valid  output  1  InstrOut holds an instruction that must execute.
REQ-015 SHALL have port Ack  output  1  program finished; held until Start drops.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-017 IDLE: ProgCtr=0, Valid=0; Start=1 -> RUN next cycle.
REQ-018 RUN, no Stall: InstrOut<=InstrIn, Valid<=1, ProgCtr<=ProgCtr+1 (mod 2^PC_W, wraps silently).
REQ-019 RUN, Stall=1: ProgCtr, InstrOut and Valid SHALL hold; Branch/Taken/Halt SHALL be ignored that cycle.
REQ-020 RUN, Valid=1, Branch=1, Taken=1, no Stall: ProgCtr<=target, Valid<=0, state<=FLUSH (squash fall-through fetch).
REQ-021 FLUSH: InstrOut<=InstrIn(target), Valid<=1, ProgCtr<=target+1, state<=RUN; branch taken penalty is exactly one bubble cycle.
REQ-022 Branch=1 with Taken=0 SHALL behave as REQ-018 (no bubble).
REQ-023 RUN, Valid=1, Halt=1, no Stall: Valid<=0, ProgCtr holds, state<=DONE; Halt SHALL take priority over Branch.
REQ-024 DONE: Ack=1, Valid=0; Start=0 -> IDLE.
REQ-025 Branch, Taken, Halt SHALL be ignored whenever Valid=0.
REQ-026 Priority per cycle: Reset > Stall > Halt > taken branch > increment.
REQ-027 Ack SHALL be registered; asserted only in DONE.

Reset
REQ-028 Reset=1 SHALL immediately force state=IDLE, ProgCtr=0, InstrOut=0, Valid=0, Ack=0, regardless of clock, including mid-FLUSH or mid-stall.
REQ-029 After Reset deasserts, no state change SHALL occur until a rising Clk with Start=1.

Configuration
REQ-030 With FETCH_BRANCH_LUT_EN defined: target = 16-entry PC_W-bit constant LUT indexed by TargetSel[3:0]; upper TargetSel bits ignored; LUT contents set by localparam table.
REQ-031 Without FETCH_BRANCH_LUT_EN: target = address of the branch instruction (ProgCtr-1) + TargetSel as two's-complement, mod 2^PC_W.

Verification
REQ-032 Reset, Start=1, ROM words 0..3 sequential -> ProgCtr 0,1,2,3; Valid=1 from 2nd cycle after Start; InstrOut = ROM[n] one cycle after ProgCtr=n.
REQ-033 Taken branch at address 5, offset build: TargetSel=-3 -> ProgCtr=2 next cycle, Valid=0 one cycle, then InstrOut=ROM[2], Valid=1; ROM[6] never valid.
REQ-034 LUT build: LUT[4]=0x20, TargetSel=4 taken -> ProgCtr=0x20, one bubble; Taken=0 same stimulus -> no bubble, ProgCtr+1.
REQ-035 Stall=1 for 3 cycles with Branch=Taken=1 -> ProgCtr/InstrOut unchanged; branch acts on first unstalled cycle.
REQ-036 Halt=1 at address 7 -> Ack=1 next cycle, Valid=0; Start held -> Ack stays 1; Start=0 -> IDLE, ProgCtr=0.
REQ-037 Reset pulsed mid-clock during FLUSH -> outputs zero immediately, state IDLE; ProgCtr=0x3FF increment -> wraps to 0.
